// File: rtl/wasca_hex_pkg.sv
// wasca_hex_pkg: shared register map, CTRL field offsets and hex glyph table
// for the wasca hex display slave.
package wasca_hex_pkg;
  localparam logic [3:0] ADDR_VALUE     = 4'd0;
  localparam logic [3:0] ADDR_CTRL      = 4'd1;
  localparam logic [3:0] ADDR_BLINK_DIV = 4'd2;
  localparam logic [3:0] ADDR_DP        = 4'd3;
  localparam logic [3:0] ADDR_RAW_BASE  = 4'd4;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_DUTY  = 4;
  localparam int CTRL_RAW   = 8;
  localparam int CTRL_BLINK = 16;
  // Segment patterns, 1 = lit, bit0 = a .. bit6 = g; b and d are lower case.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/wasca_hex_seg_decoder.sv
// wasca_hex_seg_decoder: combinational hex nibble to 7-segment pattern.
//  nibble  in   4  hex value
//  seg     out  7  segment pattern, 1 = lit, bit0 = a .. bit6 = g
module wasca_hex_seg_decoder
  import wasca_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb seg = SEG_TABLE[nibble];
endmodule

// File: rtl/wasca_hex_display.sv
// wasca_hex_display: Avalon-MM slave driving NUM_DIGITS 7-segment digits with
// decimal points, per-digit raw/blink control, global enable and PWM dimming.
//  clk, reset            clock, asynchronous active-high reset
//  address, chipselect,
//  write_n, writedata    Avalon-MM write port, zero wait states
//  readdata              combinational readback of the addressed register
//  out_port              segments, digit i at [7i+6:7i]
//  dp_port               decimal point per digit, same polarity as out_port
module wasca_hex_display
  import wasca_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_W    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] out_port,
  output logic [NUM_DIGITS-1:0]   dp_port
);
  localparam logic POL = logic'(ACTIVE_LOW != 0);
  logic                    wr;
  logic [4*NUM_DIGITS-1:0] value_r;
  logic                    enable;
  logic [3:0]              duty;
  logic [NUM_DIGITS-1:0]   raw_mask, blink_mask, dp_mask;
  logic [BLINK_W-1:0]      blink_div, blink_cnt;
  logic                    blink_phase;
  logic [3:0]              pwm_cnt;
  logic                    pwm_on;
  logic [6:0]              raw_r [NUM_DIGITS];
  logic [6:0]              dec [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_nxt;
  logic [NUM_DIGITS-1:0]   dp_nxt;
  assign wr = chipselect & ~write_n;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    wasca_hex_seg_decoder u_dec (.nibble(value_r[4*g +: 4]), .seg(dec[g]));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r    <= '0;
      enable     <= 1'b1;
      duty       <= 4'd15;
      raw_mask   <= '0;
      blink_mask <= '0;
      blink_div  <= '0;
      dp_mask    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) raw_r[i] <= '0;
    end else if (wr) begin
      if (address == ADDR_VALUE) value_r <= writedata[4*NUM_DIGITS-1:0];
      if (address == ADDR_CTRL) begin
        enable     <= writedata[CTRL_EN];
        duty       <= writedata[CTRL_DUTY +: 4];
        raw_mask   <= writedata[CTRL_RAW +: NUM_DIGITS];
        blink_mask <= writedata[CTRL_BLINK +: NUM_DIGITS];
      end
      if (address == ADDR_BLINK_DIV) blink_div <= writedata[BLINK_W-1:0];
      if (address == ADDR_DP) dp_mask <= writedata[NUM_DIGITS-1:0];
      for (int i = 0; i < NUM_DIGITS; i++)
        if (address == ADDR_RAW_BASE + 4'(i)) raw_r[i] <= writedata[6:0];
    end
  end
  // A BLINK_DIV write restarts the period in the "on" phase and beats a
  // coincident wrap; >= keeps the count sane if the divider shrinks mid-count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if ((wr && address == ADDR_BLINK_DIV) || blink_div == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt >= blink_div - BLINK_W'(1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt == 4'd14 ? 4'd0 : pwm_cnt + 4'd1;
  end
  assign pwm_on = pwm_cnt < duty;
  always_comb begin
    seg_nxt = '0;
    dp_nxt  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (enable && pwm_on && !(blink_mask[i] && !blink_phase)) begin
        seg_nxt[7*i +: 7] = raw_mask[i] ? raw_r[i] : dec[i];
        dp_nxt[i]         = dp_mask[i];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= {(7*NUM_DIGITS){POL}};
      dp_port  <= {NUM_DIGITS{POL}};
    end else begin
      out_port <= seg_nxt ^ {(7*NUM_DIGITS){POL}};
      dp_port  <= dp_nxt ^ {NUM_DIGITS{POL}};
    end
  end
  always_comb begin
    readdata = '0;
    if (address == ADDR_VALUE) readdata[4*NUM_DIGITS-1:0] = value_r;
    if (address == ADDR_CTRL) begin
      readdata[CTRL_EN]                   = enable;
      readdata[CTRL_DUTY +: 4]            = duty;
      readdata[CTRL_RAW +: NUM_DIGITS]    = raw_mask;
      readdata[CTRL_BLINK +: NUM_DIGITS]  = blink_mask;
    end
    if (address == ADDR_BLINK_DIV) readdata[BLINK_W-1:0] = blink_div;
    if (address == ADDR_DP) readdata[NUM_DIGITS-1:0] = dp_mask;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (address == ADDR_RAW_BASE + 4'(i)) readdata[6:0] = raw_r[i];
  end
endmodule

// File: tb/tb_wasca_hex_display.sv
// tb_wasca_hex_display: scoreboard bench for wasca_hex_display (6 digits, active low).
module tb_wasca_hex_display;
  logic        clk = 0;
  logic        reset = 0;
  logic [3:0]  address = 0;
  logic        chipselect = 0;
  logic        write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] readdata;
  logic [41:0] out_port;
  logic [5:0]  dp_port;
  wasca_hex_display #(.NUM_DIGITS(6), .ACTIVE_LOW(1), .BLINK_W(24)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .dp_port(dp_port)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          due;
    int          kind;
    logic [41:0] exp;
    string       name;
  } exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rel;
  logic [6:0]  pats [6];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    int i;
    logic [41:0] act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        act = q[i].kind == 0 ? out_port : q[i].kind == 1 ? {36'b0, dp_port} : {10'b0, readdata};
        checks++;
        if (q[i].due < cyc) begin
          errors++;
          $display("FAIL %s: check missed its cycle %0d (now %0d)", q[i].name, q[i].due, cyc);
        end else if (act !== q[i].exp) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h expected %h", q[i].name, cyc, act, q[i].exp);
        end
        q.delete(i);
      end else i++;
    end
  end
  function automatic logic [41:0] exp_out(logic [5:0] blank);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = blank[i] ? 7'h7F : ~pats[i];
    return r;
  endfunction
  task automatic push(int due, int kind, logic [41:0] exp, string name);
    exp_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask
  task automatic wr(logic [3:0] a, logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(logic [3:0] a, logic [31:0] e, string name);
    address = a;
    push(cyc, 2, {10'b0, e}, name);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask
  initial begin
    int c0;
    for (int i = 0; i < 6; i++) pats[i] = 7'h3F;
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 0, {42{1'b1}}, "reset_out_unlit");
    push(cyc, 1, 42'h3F, "reset_dp_unlit");
    reset = 0;
    rel = cyc;
    push(cyc + 1, 0, exp_out(6'h00), "first_clk_zeros");
    rd(4'd1, 32'h0000_00F1, "rd_ctrl_reset");
    rd(4'd0, 32'h0, "rd_value_reset");
    drain();
    // Hex decode A..F
    wr(4'd0, 32'h00FE_DCBA);
    push(cyc, 0, exp_out(6'h00), "value_not_yet");
    pats = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    push(cyc + 1, 0, exp_out(6'h00), "value_AtoF");
    drain();
    rd(4'd0, 32'h00FE_DCBA, "rd_value");
    // Raw mode on digit2, unmapped write
    wr(4'd6, 32'h0000_0049);
    wr(4'd1, 32'h0000_04F1);
    pats[2] = 7'h49;
    push(cyc + 1, 0, exp_out(6'h00), "raw_digit2");
    drain();
    wr(4'd15, 32'hFFFF_FFFF);
    push(cyc + 1, 0, exp_out(6'h00), "unmapped_write_ignored");
    drain();
    rd(4'd15, 32'h0, "rd_unmapped");
    rd(4'd6, 32'h49, "rd_raw2");
    rd(4'd1, 32'h0000_04F1, "rd_ctrl_raw");
    rd(4'd0, 32'h00FE_DCBA, "rd_value_after_unmapped");
    // Blink on digit0 with period 4, restarted mid blank phase
    wr(4'd1, 32'h0001_04F1);
    wr(4'd2, 32'd4);
    c0 = cyc;
    for (int k = 1; k <= 6; k++)
      push(c0 + k, 0, exp_out(k >= 5 ? 6'h01 : 6'h00), "blink");
    repeat (4) @(posedge clk);
    #1;
    wr(4'd2, 32'd4);
    for (int k = 7; k <= 15; k++)
      push(c0 + k, 0, exp_out((k >= 11 && k <= 14) ? 6'h01 : 6'h00), "blink_restart");
    drain();
    rd(4'd2, 32'd4, "rd_blink_div");
    wr(4'd1, 32'h0000_04F1);
    wr(4'd2, 32'd0);
    push(cyc + 1, 0, exp_out(6'h00), "blink_off");
    drain();
    // PWM: duty 5, duty 0, enable off
    wr(4'd1, 32'h0000_0451);
    c0 = cyc;
    for (int k = 1; k <= 15; k++)
      push(c0 + k, 0, exp_out(((c0 + k - rel - 1) % 15) < 5 ? 6'h00 : 6'h3F), "pwm_duty5");
    drain();
    wr(4'd1, 32'h0000_0401);
    c0 = cyc;
    for (int k = 1; k <= 15; k++) push(c0 + k, 0, exp_out(6'h3F), "pwm_duty0");
    drain();
    wr(4'd1, 32'h0000_04F0);
    c0 = cyc;
    for (int k = 1; k <= 5; k++) push(c0 + k, 0, exp_out(6'h3F), "enable_off");
    drain();
    wr(4'd1, 32'h0000_04F1);
    push(cyc + 1, 0, exp_out(6'h00), "enable_on");
    drain();
    // Decimal points, then async reset mid-blink
    wr(4'd3, 32'h0000_003F);
    push(cyc + 1, 1, 42'h00, "dp_lit");
    drain();
    rd(4'd3, 32'h3F, "rd_dp");
    wr(4'd1, 32'h0001_04F1);
    wr(4'd2, 32'd4);
    c0 = cyc;
    push(c0 + 5, 0, exp_out(6'h01), "blink_before_reset");
    push(c0 + 5, 1, 42'h01, "dp_blink_before_reset");
    repeat (6) @(posedge clk);
    #3;
    reset = 1;
    push(cyc, 0, {42{1'b1}}, "async_reset_out");
    push(cyc, 1, 42'h3F, "async_reset_dp");
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 6; i++) pats[i] = 7'h3F;
    push(cyc + 1, 0, exp_out(6'h00), "post_reset_zeros");
    rd(4'd0, 32'h0, "rd_value_rst2");
    rd(4'd1, 32'h0000_00F1, "rd_ctrl_rst2");
    rd(4'd2, 32'h0, "rd_blink_div_rst2");
    rd(4'd3, 32'h0, "rd_dp_rst2");
    rd(4'd6, 32'h0, "rd_raw2_rst2");
    drain();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL queue_drain: %0d checks left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
